// File: rtl/hold_ctrl.sv
// hold_ctrl: pipeline hold/flush scheduler for the 5-stage core.
//
// Merges the stall sources from ID (load-use), EX (multi-cycle mul/div) and
// MEM (data AXI busy) into one priority hold_code. It also sequences
// branch/jump redirects into the PC. A redirect that the PC cannot take yet
// is parked in a pending register, and the flush strobes stay asserted for
// as long as the redirect is outstanding.
//
// Ports:
//   clk, rst       core clock, asynchronous active-high reset
//   ld_use_hzd     ID load-use hazard (level)
//   mc_start       EX multi-cycle op start (1-cycle pulse)
//   mem_busy       data-side AXI not idle (level)
//   axi_idle_if    instruction-side AXI idle
//   jmp_req        EX redirect request (1-cycle pulse)
//   jmp_addr       redirect target
//   hold_code      0=NONE 1=PC 2=IF 3=ID 4=EX 5=MEM (holds stage k and earlier)
//   jmp_en, jmp_to redirect strobe and target to pc
//   flush_if_id    clear IF/ID, high while a redirect is outstanding
//   flush_id_ex    clear ID/EX, high in the jmp_req cycle only
//   mc_busy        multi-cycle op in progress
//
// Optional build macro HOLD_CTRL_PERF_EN adds the following:
//   stall_clr      synchronous clear of the stall counter
//   stall_cnt      saturating count of cycles with a hold or a pending redirect
//
// FSM states:
//   state   | meaning
//   IDLE    | no multi-cycle op; mc_start launches one
//   MCYC    | EX multi-cycle op running; mc_cnt counts remaining cycles

module hold_ctrl #(
    parameter int HOLD_W = 3,
    parameter int ADDR_W = 32,
    parameter int MC_LAT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_use_hzd,
    input  logic              mc_start,
    input  logic              mem_busy,
    input  logic              axi_idle_if,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [HOLD_W-1:0] hold_code,
    output logic              jmp_en,
    output logic [ADDR_W-1:0] jmp_to,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              mc_busy
`ifdef HOLD_CTRL_PERF_EN
    ,
    input  logic              stall_clr,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [HOLD_W-1:0] HC_NONE = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HC_ID   = HOLD_W'(3);
    localparam logic [HOLD_W-1:0] HC_EX   = HOLD_W'(4);
    localparam logic [HOLD_W-1:0] HC_MEM  = HOLD_W'(5);
    localparam logic [7:0]        MC_LOAD = 8'(MC_LAT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MCYC = 1'b1
    } state_t;

    state_t             r_state;
    logic [7:0]         r_mc_cnt;
    logic               r_pend_vld;
    logic [ADDR_W-1:0]  r_pend_addr;

    logic               w_mc_active;
    logic [HOLD_W-1:0]  w_hold_code;
    logic               w_req;
    logic [ADDR_W-1:0]  w_new_addr;
    logic               w_pc_accept;

    // The start cycle already counts as a held EX cycle.
    assign w_mc_active = (r_state == ST_MCYC) | ((r_state == ST_IDLE) & mc_start);

    always_comb begin
        w_hold_code = HC_NONE;
        if (mem_busy) begin
            w_hold_code = HC_MEM;
        end else if (w_mc_active) begin
            w_hold_code = HC_EX;
        end else if (ld_use_hzd) begin
            w_hold_code = HC_ID;
        end
    end

    // A fresh jmp_req always overrides an older parked target.
    assign w_req       = jmp_req | r_pend_vld;
    assign w_new_addr  = jmp_req ? jmp_addr : r_pend_addr;
    assign w_pc_accept = (w_hold_code == HC_NONE) & axi_idle_if;

    // The combinational paths are forced low during reset so that the outputs
    // read 0 no matter what the inputs are doing.
    assign hold_code   = rst ? HC_NONE : w_hold_code;
    assign jmp_en      = ~rst & w_req;
    assign jmp_to      = rst ? '0 : w_new_addr;
    assign flush_if_id = ~rst & w_req;
    assign flush_id_ex = ~rst & jmp_req;
    assign mc_busy     = ~rst & w_mc_active;

    // Multi-cycle sequencer. mc_cnt freezes while MEM holds the pipe, so the
    // EX hold stretches by exactly the number of mem_busy cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mc_cnt <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            if (mc_start) begin
                r_state  <= ST_MCYC;
                r_mc_cnt <= MC_LOAD;
            end
        end else begin
            if (!mem_busy) begin
                r_mc_cnt <= r_mc_cnt - 8'd1;
                if (r_mc_cnt == 8'd1) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
        end else if (w_req) begin
            if (w_pc_accept) begin
                r_pend_vld <= 1'b0;
            end else begin
                r_pend_vld  <= 1'b1;
                r_pend_addr <= w_new_addr;
            end
        end
    end

`ifdef HOLD_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (stall_clr) begin
            r_stall_cnt <= 32'd0;
        end else if (((w_hold_code != HC_NONE) | r_pend_vld) &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
